// File: rtl/fft_frame_ctrl_pkg.sv
// fft_frame_ctrl_pkg: shared state encoding, size
// constants and magnitude helper for the frame sequencer.
package fft_frame_ctrl_pkg;

  localparam int NFFT_LOG2_DEF = 13;
  localparam int NFFT = 2 ** NFFT_LOG2_DEF;
  localparam int XK_W_DEF = 38;
  localparam int TIMEOUT_DEF = 65536;
  localparam int TO_W = $clog2(TIMEOUT_DEF + 1);

  typedef enum logic [2:0] {
    IDLE,
    CFG,
    START,
    LOAD,
    XFORM,
    UNLOAD,
    STREAM,
    FINISH
  } state_e;

  // |a| + |b| on sign-extended operands; never overflows
  // for source widths up to 63 bits.
  function automatic logic [63:0] abs_sum(
    input logic signed [63:0] a,
    input logic signed [63:0] b
  );
    logic [63:0] ua;
    logic [63:0] ub;
    ua = a[63] ? 64'(-a) : 64'(a);
    ub = b[63] ? 64'(-b) : 64'(b);
    return ua + ub;
  endfunction

endpackage

// File: rtl/fft_peak_tracker.sv
// fft_peak_tracker: running maximum of |re|+|im| over
// the eligible bins of one unloaded frame.
module fft_peak_tracker
  import fft_frame_ctrl_pkg::*;
#(
  parameter int NFFT_LOG2 = NFFT_LOG2_DEF,
  parameter int XK_W = XK_W_DEF,
  parameter bit HALF_SPECTRUM = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    valid,
  input  logic [NFFT_LOG2-1:0]    index,
  input  logic signed [XK_W-1:0]  re,
  input  logic signed [XK_W-1:0]  im,
  output logic [NFFT_LOG2-1:0]    max_bin,
  output logic [XK_W:0]           max_mag
);

  logic [63:0] mag;
  logic elig;
  logic upd;
  logic [NFFT_LOG2-1:0] bin_q, bin_d;
  logic [XK_W:0] mag_q, mag_d;

  // Strictly-greater compare keeps the earliest bin on ties
  always_comb begin
    mag = abs_sum(64'(re), 64'(im));
    elig = !HALF_SPECTRUM || !index[NFFT_LOG2-1];
    upd = valid && elig && (mag > 64'(mag_q));
    bin_d = bin_q;
    mag_d = mag_q;
    if (clear) begin
      bin_d = '0;
      mag_d = '0;
    end else if (upd) begin
      bin_d = index;
      mag_d = mag[XK_W:0];
    end
  end

  // Running-max registers
  always_ff @(posedge clk) begin
    if (reset) begin
      bin_q <= '0;
      mag_q <= '0;
    end else begin
      bin_q <= bin_d;
      mag_q <= mag_d;
    end
  end

  assign max_bin = bin_q;
  assign max_mag = mag_q;

endmodule

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: sequences one FFT frame through the
// core (configure, load, transform, unload, peak search).
module fft_frame_ctrl
  import fft_frame_ctrl_pkg::*;
#(
  parameter int NFFT_LOG2 = NFFT_LOG2_DEF,
  parameter int XK_W = XK_W_DEF,
  parameter bit HALF_SPECTRUM = 1'b1,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    go,
  input  logic                    inverse,
  output logic                    ctrl_busy,
  output logic                    fft_start,
  output logic                    fft_unload,
  output logic                    fft_fwd_inv,
  output logic                    fft_fwd_inv_we,
  input  logic                    fft_rfd,
  input  logic [NFFT_LOG2-1:0]    fft_xn_index,
  input  logic                    fft_busy,
  input  logic                    fft_done,
  input  logic                    fft_dv,
  input  logic [NFFT_LOG2-1:0]    fft_xk_index,
  input  logic signed [XK_W-1:0]  fft_xk_re,
  input  logic signed [XK_W-1:0]  fft_xk_im,
  output logic [NFFT_LOG2-1:0]    buf_rd_addr,
  output logic [NFFT_LOG2-1:0]    peak_bin,
  output logic [XK_W:0]           peak_mag,
  output logic                    frame_done,
  output logic                    error
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic seen_q, seen_d;
  logic fwd_q, fwd_d;
  logic err_q, err_d;
  logic [NFFT_LOG2-1:0] addr_q, addr_d;
  logic [NFFT_LOG2-1:0] pbin_q, pbin_d;
  logic [XK_W:0] pmag_q, pmag_d;
  logic [NFFT_LOG2-1:0] mbin;
  logic [XK_W:0] mmag;
  logic counting;
  logic expired;

  fft_peak_tracker #(
    .NFFT_LOG2     (NFFT_LOG2),
    .XK_W          (XK_W),
    .HALF_SPECTRUM (HALF_SPECTRUM)
  ) u_peak (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_q == UNLOAD),
    .valid   (state_q == STREAM && fft_dv),
    .index   (fft_xk_index),
    .re      (fft_xk_re),
    .im      (fft_xk_im),
    .max_bin (mbin),
    .max_mag (mmag)
  );

  // Next state, watchdog and held outputs
  always_comb begin
    state_d = state_q;
    seen_d = seen_q;
    fwd_d = fwd_q;
    err_d = err_q;
    addr_d = addr_q;
    pbin_d = pbin_q;
    pmag_d = pmag_q;
    counting = state_q inside {LOAD, XFORM, STREAM};
    expired = counting && (cnt_q == TO_LAST);
    cnt_d = counting ? cnt_q + 1'b1 : cnt_q;
    unique case (state_q)
      IDLE: begin
        if (go && !fft_busy && !fft_dv) begin
          fwd_d = ~inverse;
          err_d = 1'b0;
          state_d = CFG;
        end
      end
      CFG: state_d = START;
      START: state_d = LOAD;
      LOAD: begin
        if (fft_rfd) begin
          addr_d = fft_xn_index;
          seen_d = 1'b1;
        end
        if (fft_done || expired) begin
          err_d = 1'b1;
          state_d = IDLE;
        end else if (!fft_rfd && seen_q) begin
          state_d = XFORM;
        end
      end
      XFORM: begin
        if (expired) begin
          err_d = 1'b1;
          state_d = IDLE;
        end else if (fft_done) begin
          state_d = UNLOAD;
        end
      end
      UNLOAD: state_d = STREAM;
      STREAM: begin
        if (expired) begin
          err_d = 1'b1;
          state_d = IDLE;
        end else if (fft_dv) begin
          seen_d = 1'b1;
        end else if (seen_q) begin
          pbin_d = mbin;
          pmag_d = mmag;
          state_d = FINISH;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) begin
      cnt_d = '0;
      seen_d = 1'b0;
    end
  end

  // State and held-output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      seen_q <= 1'b0;
      fwd_q <= 1'b0;
      err_q <= 1'b0;
      addr_q <= '0;
      pbin_q <= '0;
      pmag_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      seen_q <= seen_d;
      fwd_q <= fwd_d;
      err_q <= err_d;
      addr_q <= addr_d;
      pbin_q <= pbin_d;
      pmag_q <= pmag_d;
    end
  end

  assign ctrl_busy = (state_q != IDLE);
  assign fft_fwd_inv_we = (state_q == CFG);
  assign fft_start = (state_q == START);
  assign fft_unload = (state_q == UNLOAD);
  assign frame_done = (state_q == FINISH);
  assign fft_fwd_inv = fwd_q;
  assign error = err_q;
  assign peak_bin = pbin_q;
  assign peak_mag = pmag_q;
  assign buf_rd_addr = (state_q == LOAD && fft_rfd)
                     ? fft_xn_index : addr_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl: scoreboard bench driving a simple
// core model into two differently configured sequencers.
module tb_fft_frame_ctrl;

  localparam int NL = 13;
  localparam int XW = 38;
  localparam longint P37 = longint'(1) << 37;

  typedef struct {
    int bin;
    longint mag;
  } pk_t;

  logic clk = 1'b0;
  logic reset, go, inverse, rfd, busy, done, dv;
  logic [NL-1:0] xn_index, xk_index;
  logic signed [XW-1:0] xk_re, xk_im;

  logic busy_a, start_a, unload_a, fwd_a, we_a;
  logic done_a, err_a;
  logic [NL-1:0] addr_a, bin_a;
  logic [XW:0] mag_a;
  logic busy_b, start_b, unload_b, fwd_b, we_b;
  logic done_b, err_b;
  logic [NL-1:0] addr_b, bin_b;
  logic [XW:0] mag_b;

  int n_pass = 0;
  int n_tot = 0;
  int cyc = 0;
  int we_cyc_a = 0;
  int start_cnt_a = 0;
  int unload_cnt_a = 0;
  int addr_ok = 0;
  bit load_chk = 1'b0;

  pk_t exp_a[$];
  pk_t exp_b[$];
  bit dir_a[$];
  bit dir_b[$];
  int s_idx[$];
  longint s_re[$];
  longint s_im[$];

  fft_frame_ctrl dut_a (
    .clk (clk), .reset (reset), .go (go),
    .inverse (inverse), .ctrl_busy (busy_a),
    .fft_start (start_a), .fft_unload (unload_a),
    .fft_fwd_inv (fwd_a), .fft_fwd_inv_we (we_a),
    .fft_rfd (rfd), .fft_xn_index (xn_index),
    .fft_busy (busy), .fft_done (done), .fft_dv (dv),
    .fft_xk_index (xk_index), .fft_xk_re (xk_re),
    .fft_xk_im (xk_im), .buf_rd_addr (addr_a),
    .peak_bin (bin_a), .peak_mag (mag_a),
    .frame_done (done_a), .error (err_a)
  );

  fft_frame_ctrl #(
    .HALF_SPECTRUM (1'b0),
    .TIMEOUT (64)
  ) dut_b (
    .clk (clk), .reset (reset), .go (go),
    .inverse (inverse), .ctrl_busy (busy_b),
    .fft_start (start_b), .fft_unload (unload_b),
    .fft_fwd_inv (fwd_b), .fft_fwd_inv_we (we_b),
    .fft_rfd (rfd), .fft_xn_index (xn_index),
    .fft_busy (busy), .fft_done (done), .fft_dv (dv),
    .fft_xk_index (xk_index), .fft_xk_re (xk_re),
    .fft_xk_im (xk_im), .buf_rd_addr (addr_b),
    .peak_bin (bin_b), .peak_mag (mag_b),
    .frame_done (done_b), .error (err_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input longint act,
                     input longint exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d",
                  name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input int idx,
                     input longint re,
                     input longint im);
    s_idx.push_back(idx);
    s_re.push_back(re);
    s_im.push_back(im);
  endtask

  // Monitor: pops expectations whenever the DUTs pulse
  always @(negedge clk) begin
    pk_t e;
    if (load_chk && rfd && addr_a == xn_index)
      addr_ok++;
    if (we_a) begin
      we_cyc_a = cyc;
      if (dir_a.size() == 0) chk("unexp_we_a", 1, 0);
      else chk("dir_a", fwd_a, dir_a.pop_front());
    end
    if (start_a) begin
      start_cnt_a++;
      chk("start_lat_a", cyc - we_cyc_a, 1);
    end
    if (unload_a) unload_cnt_a++;
    if (done_a) begin
      if (exp_a.size() == 0) chk("unexp_done_a", 1, 0);
      else begin
        e = exp_a.pop_front();
        chk("bin_a", bin_a, e.bin);
        chk("mag_a", mag_a, e.mag);
      end
    end
    if (we_b) begin
      if (dir_b.size() == 0) chk("unexp_we_b", 1, 0);
      else chk("dir_b", fwd_b, dir_b.pop_front());
    end
    if (done_b) begin
      if (exp_b.size() == 0) chk("unexp_done_b", 1, 0);
      else begin
        e = exp_b.pop_front();
        chk("bin_b", bin_b, e.bin);
        chk("mag_b", mag_b, e.mag);
      end
    end
  end

  // One frame through the core model
  task automatic frame(input bit inv,
                       input int nload,
                       input int gap,
                       input bit mid_go,
                       input int rst_at,
                       input bit wd);
    int s0, u0, a0, n, k;
    s0 = start_cnt_a;
    u0 = unload_cnt_a;
    a0 = addr_ok;
    dir_a.push_back(!inv);
    dir_b.push_back(!inv);
    go = 1'b1;
    inverse = inv;
    tick();
    go = 1'b0;
    chk("err_b_clr", err_b, 0);
    tick();
    tick();
    busy = 1'b1;
    rfd = 1'b1;
    load_chk = 1'b1;
    for (int i = 0; i < nload; i++) begin
      xn_index = NL'(i);
      go = mid_go && (i == 5);
      tick();
    end
    go = 1'b0;
    rfd = 1'b0;
    load_chk = 1'b0;
    k = cyc + 1;
    tick();
    chk("addr_track", addr_ok - a0, nload);
    chk("addr_hold", addr_a, nload - 1);
    if (wd) begin
      n = 0;
      while (!err_b && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("wd_delay", cyc - k, 64);
      chk("wd_idle", busy_b, 0);
      chk("wd_a_busy", busy_a, 1);
      @(posedge clk);
      #1;
    end
    for (int g = 0; g < gap; g++) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    tick();
    for (int i = 0; i < s_idx.size(); i++) begin
      dv = 1'b1;
      xk_index = NL'(s_idx[i]);
      xk_re = XW'(s_re[i]);
      xk_im = XW'(s_im[i]);
      go = (mid_go && i == 1) ||
           (rst_at >= 0 && i == rst_at + 1);
      reset = (i == rst_at);
      tick();
      reset = 1'b0;
      if (i == rst_at) begin
        chk("rst_busy", busy_a, 0);
        chk("rst_bin", bin_a, 0);
        chk("rst_mag", mag_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_fwd", fwd_a, 0);
        chk("rst_addr", addr_a, 0);
        chk("rst_done", done_a, 0);
      end
    end
    go = 1'b0;
    dv = 1'b0;
    tick();
    busy = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    if (rst_at >= 0) chk("rst_go_rej", busy_a, 0);
    chk("one_start", start_cnt_a - s0, 1);
    chk("one_unload", unload_cnt_a - u0, 1);
    chk("idle_after", busy_a, 0);
    s_idx.delete();
    s_re.delete();
    s_im.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: sim did not end");
    $fatal(1, "timeout");
  end

  initial begin
    int s0;
    reset = 1'b1;
    go = 1'b0;
    inverse = 1'b0;
    rfd = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    dv = 1'b0;
    xn_index = '0;
    xk_index = '0;
    xk_re = '0;
    xk_im = '0;
    repeat (3) tick();
    chk("rst0_busy", busy_a | busy_b, 0);
    chk("rst0_pulses", start_a | unload_a | we_a
                       | start_b | unload_b | we_b, 0);
    chk("rst0_fwd", fwd_a | fwd_b, 0);
    chk("rst0_done", done_a | done_b, 0);
    chk("rst0_err", err_a | err_b, 0);
    chk("rst0_addr", addr_a | addr_b, 0);
    chk("rst0_bin", bin_a | bin_b, 0);
    chk("rst0_mag", mag_a | mag_b, 0);
    reset = 1'b0;
    tick();

    // Forward full-length frame; dut_b times out in LOAD
    for (int i = 0; i < 8192; i++) begin
      if (i == 300) add(i, 1000, -500);
      else add(i, 1, 1);
    end
    exp_a.push_back('{300, 1500});
    frame(1'b0, 8192, 100, 1'b0, -1, 1'b0);
    chk("t1_err_b", err_b, 1);
    chk("t1_err_a", err_a, 0);

    // Inverse, half vs full spectrum
    add(0, 1, 1);
    add(1, 1, 1);
    add(12, -3000, 5000);
    add(100, 1, 1);
    add(5000, 4500, -4500);
    add(6000, 1, 1);
    exp_a.push_back('{12, 8000});
    exp_b.push_back('{5000, 9000});
    frame(1'b1, 16, 10, 1'b0, -1, 1'b0);
    chk("t2_fwd_hold", fwd_a, 0);

    // Tie at extreme magnitude keeps earlier bin
    add(3, 1, 1);
    add(7, -P37, 5);
    add(9, P37 - 1, 6);
    add(10, 1, 1);
    exp_a.push_back('{7, P37 + 5});
    exp_b.push_back('{7, P37 + 5});
    frame(1'b0, 16, 10, 1'b0, -1, 1'b0);

    // Watchdog on dut_b while dut_a waits for done
    add(2, 3, -4);
    add(4000, 10, 10);
    exp_a.push_back('{4000, 20});
    frame(1'b0, 20, 0, 1'b0, -1, 1'b1);
    chk("t4_err_b", err_b, 1);

    // go while busy is ignored
    add(1, 0, 0);
    add(50, -7, 8);
    exp_a.push_back('{50, 15});
    exp_b.push_back('{50, 15});
    frame(1'b1, 16, 10, 1'b1, -1, 1'b0);
    s0 = start_cnt_a;
    busy = 1'b1;
    go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    tick();
    chk("gate_busy", busy_a, 0);
    chk("gate_start", start_cnt_a - s0, 0);
    busy = 1'b0;
    tick();

    // Reset mid-stream, then a clean frame
    for (int i = 0; i < 20; i++) add(i, 1, 1);
    frame(1'b0, 16, 10, 1'b0, 5, 1'b0);
    add(0, 2, 2);
    add(4095, -100, -1);
    add(4096, 500, 500);
    exp_a.push_back('{4095, 101});
    exp_b.push_back('{4096, 1000});
    frame(1'b0, 16, 10, 1'b0, -1, 1'b0);

    repeat (4) tick();
    chk("drain_pk_a", exp_a.size(), 0);
    chk("drain_pk_b", exp_b.size(), 0);
    chk("drain_dir_a", dir_a.size(), 0);
    chk("drain_dir_b", dir_b.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/fft_frame_ctrl.md
Name: fft_frame_ctrl

Overview:
Sequencer for the 8192-point burst-I/O FFT core. On a `go` request it:
- programs the transform direction,
- starts the core and supplies sample-buffer read addresses while the core loads,
- waits for the transform to finish, then commands unload.

While the result streams out, it finds the peak-magnitude bin and reports it, with frame-done and watchdog-error indications. It sits between the sample frame buffer / system control logic and the FFT core wrapper.

Parameters:
- NFFT_LOG2, 13, log2 of transform length; sets index widths.
- XK_W, 38, width of each core output component (xk_re, xk_im).
- HALF_SPECTRUM, 1, 1 = peak search over bins 0..N/2-1 only; 0 = all N bins.
- TIMEOUT, 65536, maximum cycles allowed in any wait state before error.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- go  in  1  request one transform; sampled only in IDLE.
- inverse  in  1  direction for the requested transform; 1 = inverse, latched with go.
- ctrl_busy  out  1  high in every state except IDLE.
- fft_start  out  1  one-cycle start pulse to the core.
- fft_unload  out  1  one-cycle unload pulse to the core.
- fft_fwd_inv  out  1  core direction; 1 = forward.
- fft_fwd_inv_we  out  1  one-cycle write enable for fft_fwd_inv.
- fft_rfd  in  1  core ready-for-data.
- fft_xn_index  in  NFFT_LOG2  core input index.
- fft_busy  in  1  core busy.
- fft_done  in  1  core transform-complete pulse.
- fft_dv  in  1  core output data valid.
- fft_xk_index  in  NFFT_LOG2  core output bin index.
- fft_xk_re  in  XK_W  core output, real part, signed.
- fft_xk_im  in  XK_W  core output, imaginary part, signed.
- buf_rd_addr  out  NFFT_LOG2  sample-buffer read address.
- peak_bin  out  NFFT_LOG2  bin of the largest magnitude in the last frame.
- peak_mag  out  XK_W+1  magnitude of that bin.
- frame_done  out  1  one-cycle pulse when peak_bin/peak_mag update.
- error  out  1  sticky watchdog error.

Behaviour:
- **Reset** (synchronous, active-high): state = IDLE. Every output is 0, including peak_bin, peak_mag and error. Reset mid-operation aborts immediately; the core itself is not reset.
- **States:** IDLE, CFG, START, LOAD, XFORM, UNLOAD, STREAM, FINISH.
- **IDLE:**
  - A go pulse is accepted only when fft_busy = 0 and fft_dv = 0; otherwise it is ignored and not queued.
  - On acceptance: latch inverse, clear error, go to CFG.
- **CFG:** fft_fwd_inv = ~inverse_latched and fft_fwd_inv_we = 1 for exactly one cycle → START.
- **START:** fft_start = 1 for exactly one cycle → LOAD.
- **LOAD:**
  - buf_rd_addr = fft_xn_index, combinational, while fft_rfd = 1; otherwise it holds its last value.
  - Sample-buffer read latency is matched by the core's input-latency configuration, not by this block.
  - Go to XFORM on the first cycle fft_rfd is low after having been high.
- **XFORM:** wait for fft_done = 1 → UNLOAD.
- **UNLOAD:** fft_unload = 1 for exactly one cycle; clear the running max → STREAM.
- **STREAM**, on each cycle with fft_dv = 1:
  - mag = |xk_re| + |xk_im|, unsigned, XK_W+1 bits. |−2^(XK_W−1)| = 2^(XK_W−1) with no overflow.
  - The bin is eligible if HALF_SPECTRUM = 0, or if fft_xk_index[NFFT_LOG2−1] = 0.
  - Update the running max if eligible and mag > running max (strictly greater: ties keep the lower, earlier bin).
  - Go to FINISH on the first cycle fft_dv is low after having been high.
- **FINISH:** copy the running max into peak_bin/peak_mag; frame_done = 1 for one cycle → IDLE.
- **Pulse latency:** go accepted at cycle t gives fft_fwd_inv_we at t+1 and fft_start at t+2.
- **Watchdog:**
  - A cycle counter clears on every state entry and runs in LOAD, XFORM and STREAM.
  - When it reaches TIMEOUT: set error (sticky), go to IDLE, leave peak outputs unchanged, no frame_done.
  - Also an error: fft_done seen while in LOAD (same response).
- **Simultaneous events:** go asserted in any non-IDLE state has no effect.
- **fft_fwd_inv level:** holds its value between frames.

Decomposition:
- **Shared package:**
  - state encoding enum;
  - constants NFFT = 2**NFFT_LOG2 and TIMEOUT width = clog2(TIMEOUT+1);
  - an abs-sum magnitude function.
- **Sub-module `fft_peak_tracker`:**
  - inputs: clear, valid, index, re, im;
  - outputs: max_bin, max_mag;
  - contains the magnitude, eligibility and compare logic.
- The FSM and watchdog stay in `fft_frame_ctrl`.

Test Plan:
1. **Forward frame.** Model core: rfd high 8192 cycles, done 100 cycles later, dv for 8192 cycles. Bin 300 = (1000, −500), all others (1, 1).
   → fwd_inv_we with fwd_inv = 1, start 1 cycle later, buf_rd_addr tracks xn_index 0..8191, one unload pulse, frame_done with peak_bin = 300, peak_mag = 1500.
2. **Inverse and half-spectrum.** inverse = 1. Bin 5000 mag 9000, bin 12 mag 8000.
   → fwd_inv = 0 written; HALF_SPECTRUM = 1 gives peak_bin = 12 / 8000; HALF_SPECTRUM = 0 gives peak_bin = 5000.
3. **Tie and extreme values.** Bins 7 and 9 both mag 2^37 + 5, with re = −2^37 at bin 7.
   → peak_bin = 7, peak_mag = 2^37 + 5, no overflow.
4. **Watchdog.** Model never asserts done, TIMEOUT = 64.
   → error = 1 exactly 64 cycles after XFORM entry, ctrl_busy = 0, no frame_done; next accepted go clears error.
5. **Go gating.** go while ctrl_busy = 1 → ignored (exactly one start pulse per frame). go while fft_busy = 1 in IDLE → ignored.
6. **Reset mid-STREAM.** → all outputs 0 next cycle; go rejected until the model's dv and busy fall; then a normal frame completes.
